// File: rtl/uart_stim_pkg.sv
// Shared types and helpers for the UART transmit stimulus generator.
package uart_stim_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Length of the final (possibly shortened) stop bit, integer floor.
  function automatic int last_stop_clks(input int bit_clks, input int pct);
    return (bit_clks * pct) / 100;
  endfunction

  // Line level of the parity bit given the XOR of all payload bits.
  function automatic logic parity_bit(input logic acc, input parity_t mode);
    logic res;
    case (mode)
      PAR_EVEN: res = acc;
      PAR_ODD:  res = ~acc;
      default:  res = 1'b1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/uart_stim_tx_fifo.sv
// Single-clock FIFO with registered full/empty/count; pointers wrap modulo DEPTH.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_n;
  logic             full_r;
  logic             empty_r;
  logic             push_s;
  logic             pop_s;

  assign push_s = push & ~full_r;
  assign pop_s  = pop & ~empty_r;
  assign rdata  = mem_r[rd_ptr_r];
  assign full   = full_r;
  assign empty  = empty_r;
  assign count  = count_r;

  // Next occupancy: simultaneous push and pop leave it unchanged.
  always_comb begin
    count_n = count_r;
    case ({push_s, pop_s})
      2'b10:   count_n = count_r + CW'(1);
      2'b01:   count_n = count_r - CW'(1);
      default: count_n = count_r;
    endcase
  end

  // Storage write; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers, occupancy and registered status flags.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_n;
      full_r  <= (count_n == DEPTH_C);
      empty_r <= (count_n == {CW{1'b0}});
    end
  end

endmodule

// File: rtl/uart_stim_tx.sv
// UART transmit stimulus generator: queued bytes serialised LSB-first on txd
// with optional parity, 1-2 stop bits and a shortened final stop bit.
module uart_stim_tx
  import uart_stim_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 5208,
  parameter int DATA_BITS        = 8,
  parameter int FIFO_DEPTH       = 16,
  parameter int PARITY           = 0,
  parameter int STOP_BITS        = 1,
  parameter int STOP_PCT         = 100
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          txd,
  output logic                          busy,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BIT_CLKS  = 2 * CLK_PER_HALF_BIT;
  localparam int LAST_CLKS = last_stop_clks(BIT_CLKS, STOP_PCT);
  localparam int TW        = $clog2(BIT_CLKS);
  localparam logic [TW-1:0] FULL_END  = TW'(BIT_CLKS - 1);
  localparam logic [TW-1:0] LAST_END  = TW'(LAST_CLKS - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam parity_t       PAR_MODE  = parity_t'(2'(PARITY));

  if (PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
      STOP_PCT < 50 || STOP_PCT > 100 || DATA_BITS < 5 || DATA_BITS > 8 ||
      CLK_PER_HALF_BIT < 1 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_err
    $fatal(1, "uart_stim_tx: illegal parameter combination");
  end

  tx_state_t            state_r, state_n;
  logic [TW-1:0]        timer_r, timer_n;
  logic [TW-1:0]        bit_len_end_s;
  logic                 bit_end_s;
  logic [2:0]           bit_idx_r, bit_idx_n;
  logic [DATA_BITS-1:0] shift_r, shift_n;
  logic                 par_r, par_n;
  logic                 txd_r, txd_n;
  logic                 done_r, done_n;
  logic                 busy_r;
  logic                 pop_s;
  logic                 push_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic [DATA_BITS-1:0] fifo_rdata_s;

  assign push_s     = in_valid & in_ready;
  assign in_ready   = ~fifo_full_s;
  assign txd        = txd_r;
  assign busy       = busy_r;
  assign frame_done = done_r;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (in_data),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count)
  );

  // Next-state, bit timing and line level for the frame sequencer.
  always_comb begin
    state_n   = state_r;
    timer_n   = timer_r + TW'(1);
    bit_idx_n = bit_idx_r;
    shift_n   = shift_r;
    par_n     = par_r;
    txd_n     = txd_r;
    done_n    = 1'b0;
    pop_s     = 1'b0;
    if (state_r == STOP && bit_idx_r == STOP_LAST) begin
      bit_len_end_s = LAST_END;
    end else begin
      bit_len_end_s = FULL_END;
    end
    bit_end_s = (timer_r == bit_len_end_s);
    case (state_r)
      IDLE: begin
        timer_n = {TW{1'b0}};
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          shift_n = fifo_rdata_s;
          par_n   = 1'b0;
          txd_n   = 1'b0;
          state_n = START;
        end else begin
          txd_n   = 1'b1;
        end
      end
      START: begin
        if (bit_end_s) begin
          timer_n   = {TW{1'b0}};
          bit_idx_n = 3'd0;
          txd_n     = shift_r[0];
          par_n     = shift_r[0];
          shift_n   = shift_r >> 1;
          state_n   = DATA;
        end else begin
          txd_n     = 1'b0;
        end
      end
      DATA: begin
        if (bit_end_s && bit_idx_r == DATA_LAST) begin
          timer_n   = {TW{1'b0}};
          bit_idx_n = 3'd0;
          if (PAR_MODE != PAR_NONE) begin
            txd_n   = parity_bit(par_r, PAR_MODE);
            state_n = uart_stim_pkg::PARITY;
          end else begin
            txd_n   = 1'b1;
            state_n = STOP;
          end
        end else if (bit_end_s) begin
          timer_n   = {TW{1'b0}};
          bit_idx_n = bit_idx_r + 3'd1;
          txd_n     = shift_r[0];
          par_n     = par_r ^ shift_r[0];
          shift_n   = shift_r >> 1;
        end else begin
          state_n   = DATA;
        end
      end
      uart_stim_pkg::PARITY: begin
        if (bit_end_s) begin
          timer_n   = {TW{1'b0}};
          bit_idx_n = 3'd0;
          txd_n     = 1'b1;
          state_n   = STOP;
        end else begin
          state_n   = uart_stim_pkg::PARITY;
        end
      end
      STOP: begin
        if (bit_end_s && bit_idx_r == STOP_LAST) begin
          timer_n = {TW{1'b0}};
          done_n  = 1'b1;
          // Back-to-back frames: the next start bit begins on this edge.
          if (!fifo_empty_s) begin
            pop_s   = 1'b1;
            shift_n = fifo_rdata_s;
            par_n   = 1'b0;
            txd_n   = 1'b0;
            state_n = START;
          end else begin
            txd_n   = 1'b1;
            state_n = IDLE;
          end
        end else if (bit_end_s) begin
          timer_n   = {TW{1'b0}};
          bit_idx_n = bit_idx_r + 3'd1;
        end else begin
          txd_n     = 1'b1;
        end
      end
      default: begin
        timer_n = {TW{1'b0}};
        txd_n   = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

  // Sequencer state and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r   <= IDLE;
      timer_r   <= {TW{1'b0}};
      bit_idx_r <= 3'd0;
      shift_r   <= {DATA_BITS{1'b0}};
      par_r     <= 1'b0;
      txd_r     <= 1'b1;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_n;
      timer_r   <= timer_n;
      bit_idx_r <= bit_idx_n;
      shift_r   <= shift_n;
      par_r     <= par_n;
      txd_r     <= txd_n;
      done_r    <= done_n;
      busy_r    <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_stim_tx.sv
// Directed bench for uart_stim_tx: five instances with different parameter sets.
module tb_uart_stim_tx;

  logic       clk;
  logic [4:0] rstn_v;
  logic [4:0] vld;
  logic [4:0] rdy;
  logic [4:0] txd_w;
  logic [4:0] busy_w;
  logic [4:0] done_w;
  logic [7:0] din [5];
  logic [4:0] fc0, fc1, fc2, fc3;
  logic [2:0] fc4;
  logic [7:0] e_bytes [6];
  int         n_vec;
  int         n_err;
  int         wait_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: 8N1, half bit 4 (tests 1, 5, 6)
  uart_stim_tx #(.CLK_PER_HALF_BIT(4)) u_a (
    .clk(clk), .rstn(rstn_v[0]), .in_data(din[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
    .txd(txd_w[0]), .busy(busy_w[0]), .frame_done(done_w[0]), .fifo_count(fc0));
  // 1: even parity
  uart_stim_tx #(.CLK_PER_HALF_BIT(4), .PARITY(1)) u_b (
    .clk(clk), .rstn(rstn_v[1]), .in_data(din[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
    .txd(txd_w[1]), .busy(busy_w[1]), .frame_done(done_w[1]), .fifo_count(fc1));
  // 2: odd parity
  uart_stim_tx #(.CLK_PER_HALF_BIT(4), .PARITY(2)) u_c (
    .clk(clk), .rstn(rstn_v[2]), .in_data(din[2]), .in_valid(vld[2]), .in_ready(rdy[2]),
    .txd(txd_w[2]), .busy(busy_w[2]), .frame_done(done_w[2]), .fifo_count(fc2));
  // 3: two stop bits, last one 90 %
  uart_stim_tx #(.CLK_PER_HALF_BIT(5), .STOP_BITS(2), .STOP_PCT(90)) u_d (
    .clk(clk), .rstn(rstn_v[3]), .in_data(din[3]), .in_valid(vld[3]), .in_ready(rdy[3]),
    .txd(txd_w[3]), .busy(busy_w[3]), .frame_done(done_w[3]), .fifo_count(fc3));
  // 4: shallow FIFO
  uart_stim_tx #(.CLK_PER_HALF_BIT(4), .FIFO_DEPTH(4)) u_e (
    .clk(clk), .rstn(rstn_v[4]), .in_data(din[4]), .in_valid(vld[4]), .in_ready(rdy[4]),
    .txd(txd_w[4]), .busy(busy_w[4]), .frame_done(done_w[4]), .fifo_count(fc4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check txd level (and busy high) for n cycles, sampling on falling edges.
  task automatic expect_level(input int idx, input logic val, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s txd c%0d", tag, i), {31'd0, txd_w[idx]}, {31'd0, val});
      chk($sformatf("%s busy c%0d", tag, i), {31'd0, busy_w[idx]}, 32'd1);
      @(negedge clk);
    end
  endtask

  // Whole frame starting at the current cycle; par_bit < 0 means no parity bit.
  task automatic check_frame(input int idx, input logic [7:0] d, input int par_bit,
                             input int nfull, input int last_len, input int bc,
                             input string tag);
    expect_level(idx, 1'b0, bc, {tag, " start"});
    for (int b = 0; b < 8; b++) begin
      expect_level(idx, d[b], bc, $sformatf("%s d%0d", tag, b));
    end
    if (par_bit >= 0) begin
      expect_level(idx, par_bit[0], bc, {tag, " par"});
    end
    for (int s = 0; s < nfull; s++) begin
      expect_level(idx, 1'b1, bc, {tag, " stop"});
    end
    expect_level(idx, 1'b1, last_len, {tag, " laststop"});
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rstn_v  = 5'b00000;
    vld     = 5'b00000;
    for (int i = 0; i < 5; i++) din[i] = 8'h00;
    e_bytes = '{8'h11, 8'hE2, 8'h3C, 8'h80, 8'h7F, 8'h5B};
    @(negedge clk);
    @(negedge clk);

    // Reset state
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rst txd%0d", i),  {31'd0, txd_w[i]},  32'd1);
      chk($sformatf("rst rdy%0d", i),  {31'd0, rdy[i]},    32'd1);
      chk($sformatf("rst busy%0d", i), {31'd0, busy_w[i]}, 32'd0);
      chk($sformatf("rst done%0d", i), {31'd0, done_w[i]}, 32'd0);
    end
    chk("rst fc0", {27'd0, fc0}, 32'd0);
    chk("rst fc4", {29'd0, fc4}, 32'd0);
    rstn_v = 5'b11111;
    @(negedge clk);

    // Test 1: single byte 0x29, 8N1, one-cycle pop latency
    din[0] = 8'h29; vld[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    chk("t1 latency txd", {31'd0, txd_w[0]},  32'd1);
    chk("t1 latency busy", {31'd0, busy_w[0]}, 32'd0);
    chk("t1 queued", {27'd0, fc0}, 32'd1);
    @(negedge clk);
    chk("t1 popped", {27'd0, fc0}, 32'd0);
    check_frame(0, 8'h29, -1, 0, 8, 8, "t1");
    chk("t1 done", {31'd0, done_w[0]}, 32'd1);
    chk("t1 busy end", {31'd0, busy_w[0]}, 32'd0);
    chk("t1 txd idle", {31'd0, txd_w[0]}, 32'd1);
    @(negedge clk);
    chk("t1 done pulse", {31'd0, done_w[0]}, 32'd0);

    // Test 2: parity on 0x07 -> even 1, odd 0, 11-bit frame
    din[1] = 8'h07; din[2] = 8'h07; vld[1] = 1'b1; vld[2] = 1'b1;
    @(negedge clk);
    vld[1] = 1'b0; vld[2] = 1'b0;
    @(negedge clk);
    fork
      check_frame(1, 8'h07, 1, 0, 8, 8, "t2 even");
      check_frame(2, 8'h07, 0, 0, 8, 8, "t2 odd");
    join
    chk("t2 even done", {31'd0, done_w[1]}, 32'd1);
    chk("t2 odd done",  {31'd0, done_w[2]}, 32'd1);

    // Test 3: 2 stop bits with 90% last stop -> 10+9 high then next start
    din[3] = 8'h55; vld[3] = 1'b1;
    @(negedge clk);
    din[3] = 8'h00;
    @(negedge clk);
    vld[3] = 1'b0;
    check_frame(3, 8'h55, -1, 1, 9, 10, "t3 f0");
    chk("t3 done", {31'd0, done_w[3]}, 32'd1);
    check_frame(3, 8'h00, -1, 1, 9, 10, "t3 f1");
    chk("t3 done2", {31'd0, done_w[3]}, 32'd1);
    chk("t3 idle busy", {31'd0, busy_w[3]}, 32'd0);

    // Test 4: depth-4 FIFO, 6 consecutive pushes
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          chk($sformatf("t4 ready push%0d", i), {31'd0, rdy[4]}, (i < 5) ? 32'd1 : 32'd0);
          din[4] = e_bytes[i]; vld[4] = 1'b1;
          @(negedge clk);
        end
        wait_cnt = 0;
        while (rdy[4] !== 1'b1 && wait_cnt < 200) begin
          wait_cnt++;
          @(negedge clk);
        end
        chk("t4 ready timeout", {31'd0, rdy[4]}, 32'd1);
        chk("t4 ready at done", {31'd0, done_w[4]}, 32'd1);
        @(negedge clk);
        vld[4] = 1'b0;
        chk("t4 fc after b5", {29'd0, fc4}, 32'd4);
        chk("t4 full again", {31'd0, rdy[4]}, 32'd0);
      end
      begin
        @(negedge clk);
        @(negedge clk);
        for (int f = 0; f < 6; f++) begin
          check_frame(4, e_bytes[f], -1, 0, 8, 8, $sformatf("t4 f%0d", f));
          chk($sformatf("t4 done f%0d", f), {31'd0, done_w[4]}, 32'd1);
        end
        chk("t4 end busy", {31'd0, busy_w[4]}, 32'd0);
        chk("t4 end txd", {31'd0, txd_w[4]}, 32'd1);
      end
    join

    // Test 5: 0xA5 then 0x3C back to back, no idle gap
    din[0] = 8'hA5; vld[0] = 1'b1;
    @(negedge clk);
    din[0] = 8'h3C;
    @(negedge clk);
    vld[0] = 1'b0;
    check_frame(0, 8'hA5, -1, 0, 8, 8, "t5 f0");
    chk("t5 done0", {31'd0, done_w[0]}, 32'd1);
    check_frame(0, 8'h3C, -1, 0, 8, 8, "t5 f1");
    chk("t5 done1", {31'd0, done_w[0]}, 32'd1);
    chk("t5 idle", {31'd0, busy_w[0]}, 32'd0);
    @(negedge clk);

    // Test 6: reset during data bit 3 aborts the frame and flushes the FIFO
    din[0] = 8'h5A; vld[0] = 1'b1;
    @(negedge clk);
    din[0] = 8'hC3;
    @(negedge clk);
    vld[0] = 1'b0;
    expect_level(0, 1'b0, 8, "t6 start");
    expect_level(0, 1'b0, 8, "t6 d0");
    expect_level(0, 1'b1, 8, "t6 d1");
    expect_level(0, 1'b0, 8, "t6 d2");
    expect_level(0, 1'b1, 3, "t6 d3");
    chk("t6 fc before rst", {27'd0, fc0}, 32'd1);
    rstn_v[0] = 1'b0;
    @(negedge clk);
    chk("t6 rst txd",  {31'd0, txd_w[0]},  32'd1);
    chk("t6 rst busy", {31'd0, busy_w[0]}, 32'd0);
    chk("t6 rst fc",   {27'd0, fc0},       32'd0);
    chk("t6 rst done", {31'd0, done_w[0]}, 32'd0);
    chk("t6 rst rdy",  {31'd0, rdy[0]},    32'd1);
    rstn_v[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("t6 quiet txd c%0d", i),  {31'd0, txd_w[0]},  32'd1);
      chk($sformatf("t6 quiet done c%0d", i), {31'd0, done_w[0]}, 32'd0);
    end
    din[0] = 8'h96; vld[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    @(negedge clk);
    check_frame(0, 8'h96, -1, 0, 8, 8, "t6 clean");
    chk("t6 clean done", {31'd0, done_w[0]}, 32'd1);
    chk("t6 clean idle", {31'd0, busy_w[0]}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
